wb_timeout_arbiter: RTL and testbench

Three-master Wishbone arbiter with round-robin fairness and a per-transaction bus timeout, for sharing one slave port between the CPU instruction, CPU data and DMA masters. It sits in front of the data bus slave mux and replaces a plain priority arbiter. A slave that never answers produces an error response to the owning master and releases the bus, so the bus does not hang.

---
 rtl/wb_arb_pkg.sv | 9 +
 rtl/rr_select_3.sv | 20 ++
 rtl/wb_timeout_arbiter.sv | 116 +++++++++++
 tb/tb_wb_timeout_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared types and helpers for the Wishbone timeout arbiter.
package wb_arb_pkg;
    localparam int NUM_MASTERS = 3;
    typedef enum logic [1:0] {IDLE, GRANT, ABORT, RELEASE} arb_state_t;
    typedef logic [1:0] master_idx_t;
    function automatic master_idx_t next_idx(input master_idx_t i);
        return (i >= 2'd2) ? 2'd0 : i + 2'd1;
    endfunction
endpackage

// File: rtl/rr_select_3.sv
// rr_select_3: combinational round-robin pick among three requesters,
// scanning upward from the master after the last grant.
module rr_select_3
    import wb_arb_pkg::*;
(
    input  logic [2:0] i_req,
    input  logic [1:0] i_last,
    output logic [1:0] o_idx,
    output logic       o_valid
);
    logic [3:0]  w_req;
    master_idx_t w_c1, w_c2, w_c3;

    assign w_req   = {1'b0, i_req};
    assign w_c1    = next_idx(i_last);
    assign w_c2    = next_idx(w_c1);
    assign w_c3    = next_idx(w_c2);
    assign o_valid = |i_req;
    assign o_idx   = w_req[w_c1] ? w_c1 : w_req[w_c2] ? w_c2 : w_c3;
endmodule

// File: rtl/wb_timeout_arbiter.sv
// wb_timeout_arbiter: three-master Wishbone round-robin arbiter that aborts
// a transaction with an error when the slave stays silent too long.
module wb_timeout_arbiter
    import wb_arb_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [2:0]                    i_wbm_cyc,
    input  logic [2:0]                    i_wbm_stb,
    input  logic [2:0]                    i_wbm_we,
    input  logic [3*ADDR_WIDTH-1:0]       i_wbm_adr,
    input  logic [3*DATA_WIDTH-1:0]       i_wbm_dat,
    input  logic [3*(DATA_WIDTH/8)-1:0]   i_wbm_sel,
    output logic [2:0]                    o_wbm_ack,
    output logic [2:0]                    o_wbm_err,
    output logic [2:0]                    o_wbm_stall,
    output logic [3*DATA_WIDTH-1:0]       o_wbm_dat,
    output logic                          o_wbs_cyc,
    output logic                          o_wbs_stb,
    output logic                          o_wbs_we,
    output logic [ADDR_WIDTH-1:0]         o_wbs_adr,
    output logic [DATA_WIDTH-1:0]         o_wbs_dat,
    output logic [DATA_WIDTH/8-1:0]       o_wbs_sel,
    input  logic                          i_wbs_ack,
    input  logic                          i_wbs_err,
    input  logic                          i_wbs_stall,
    input  logic [DATA_WIDTH-1:0]         i_wbs_dat,
    output logic [1:0]                    grant_o,
    output logic                          grant_valid_o,
    output logic                          timeout_o,
    output logic [1:0]                    timeout_master_o,
    output logic [CNT_WIDTH-1:0]          timeout_count_o
);
    localparam int SW = DATA_WIDTH / 8;
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

    arb_state_t     r_state, w_next;
    master_idx_t    r_grant, r_last, r_tmo_master, w_pick;
    logic [TW-1:0]  r_timer;
    logic [CNT_WIDTH-1:0] r_tmo_count;
    logic           w_valid, w_cyc, w_hit, w_fwd, w_abort;

    rr_select_3 u_rr (
        .i_req   (i_wbm_cyc),
        .i_last  (r_last),
        .o_idx   (w_pick),
        .o_valid (w_valid)
    );

    assign w_cyc   = i_wbm_cyc[r_grant];
    assign w_hit   = i_wbs_ack | i_wbs_err;
    assign w_fwd   = (r_state == GRANT) && w_cyc;
    assign w_abort = r_state == ABORT;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_valid ? GRANT : IDLE;
            GRANT:   w_next = !w_cyc ? IDLE : (!w_hit && r_timer == T_LAST) ? ABORT : GRANT;
            ABORT:   w_next = RELEASE;
            RELEASE: w_next = w_cyc ? RELEASE : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_grant      <= 2'd0;
            r_last       <= 2'd2;
            r_timer      <= '0;
            r_tmo_master <= 2'd0;
            r_tmo_count  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_valid) begin
                r_grant <= w_pick;
                r_last  <= w_pick;
            end
            // Any response restarts the silence window; outside GRANT it idles at zero.
            r_timer <= (r_state == GRANT && w_cyc && !w_hit) ? r_timer + TW'(1) : '0;
            if (w_abort) begin
                r_tmo_master <= r_grant;
                r_tmo_count  <= &r_tmo_count ? r_tmo_count : r_tmo_count + CNT_WIDTH'(1);
            end
        end
    end

    assign o_wbs_cyc = w_fwd;
    assign o_wbs_stb = w_fwd & i_wbm_stb[r_grant];
    assign o_wbs_we  = w_fwd & i_wbm_we[r_grant];
    assign o_wbs_adr = w_fwd ? i_wbm_adr[int'(r_grant)*ADDR_WIDTH +: ADDR_WIDTH] : '0;
    assign o_wbs_dat = w_fwd ? i_wbm_dat[int'(r_grant)*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign o_wbs_sel = w_fwd ? i_wbm_sel[int'(r_grant)*SW +: SW] : '0;

    for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_m
        logic w_own;
        assign w_own          = r_grant == 2'(g);
        assign o_wbm_ack[g]   = w_own & w_fwd & i_wbs_ack;
        assign o_wbm_err[g]   = w_own & ((w_fwd & i_wbs_err) | w_abort);
        assign o_wbm_stall[g] = !(w_own & (w_abort | (w_fwd & !i_wbs_stall)));
        assign o_wbm_dat[g*DATA_WIDTH +: DATA_WIDTH] = (w_own & w_fwd) ? i_wbs_dat : '0;
    end

    assign grant_o          = r_grant;
    assign grant_valid_o    = r_state == GRANT;
    assign timeout_o        = w_abort;
    assign timeout_master_o = r_tmo_master;
    assign timeout_count_o  = r_tmo_count;
endmodule

// File: tb/tb_wb_timeout_arbiter.sv
// tb_wb_timeout_arbiter: directed tables, corner sequences and a randomized
// run against a behavioural model of the arbiter (timeout 16, 2-bit counter).
module tb_wb_timeout_arbiter;
    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  cyc = '0, stb = '0, we = '0;
    logic [95:0] adr = '0, wdat = '0;
    logic [11:0] sel = '0;
    logic [2:0]  m_ack, m_err, m_stall;
    logic [95:0] m_dat;
    logic        s_cyc, s_stb, s_we, s_ack;
    logic [31:0] s_adr, s_wdat, s_rdat = '0;
    logic [3:0]  s_sel;
    logic        auto_ack = 1'b0, f_ack = 1'b0, f_err = 1'b0, s_stall = 1'b0;
    logic [1:0]  grant, tmst, tcnt;
    logic        gv, to;

    int n_cmp = 0, n_bad = 0;

    assign s_ack = (auto_ack & s_stb) | f_ack;

    wb_timeout_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(T), .CNT_WIDTH(2)) dut (
        .clk(clk), .rst(rst),
        .i_wbm_cyc(cyc), .i_wbm_stb(stb), .i_wbm_we(we), .i_wbm_adr(adr), .i_wbm_dat(wdat), .i_wbm_sel(sel),
        .o_wbm_ack(m_ack), .o_wbm_err(m_err), .o_wbm_stall(m_stall), .o_wbm_dat(m_dat),
        .o_wbs_cyc(s_cyc), .o_wbs_stb(s_stb), .o_wbs_we(s_we), .o_wbs_adr(s_adr), .o_wbs_dat(s_wdat), .o_wbs_sel(s_sel),
        .i_wbs_ack(s_ack), .i_wbs_err(f_err), .i_wbs_stall(s_stall), .i_wbs_dat(s_rdat),
        .grant_o(grant), .grant_valid_o(gv), .timeout_o(to), .timeout_master_o(tmst), .timeout_count_o(tcnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; cyc = '0; stb = '0; f_ack = 1'b0; f_err = 1'b0; auto_ack = 1'b0;
        @(negedge clk);
        chk("rst_ctl", {gv, grant, s_cyc, s_stb, m_ack, m_err, m_stall, tmst, tcnt},
            {1'b0, 2'd0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b111, 2'd0, 2'd0});
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Behavioural reference: who owns the bus and what phase the ownership is in.
    int own, quiet, ph, last, gshow, mtm, mcnt;

    task automatic model_reset();
        own = -1; quiet = 0; ph = 0; last = 2; gshow = 0; mtm = 0; mcnt = 0;
    endtask

    task automatic model_check();
        logic [2:0]  ea, ee, es;
        logic        egv, ewc, ews, eto, fwd, found;
        logic [95:0] ed;
        int c;
        ea = '0; ee = '0; es = 3'b111; ed = '0;
        egv = 0; ewc = 0; ews = 0; eto = 0; fwd = 0; found = 0;
        if (own >= 0) begin
            egv = (ph == 0);
            fwd = egv && cyc[own];
            if (fwd) begin
                ewc = 1; ews = stb[own]; ea[own] = s_ack; ee[own] = f_err; es[own] = s_stall;
                ed[own*32 +: 32] = s_rdat;
            end
            if (ph == 1) begin ee[own] = 1; es[own] = 0; eto = 1; end
        end
        chk("rand_ctl", {gv, grant, s_cyc, s_stb, m_ack, m_err, m_stall, to, tmst, tcnt},
            {egv, 2'(gshow), ewc, ews, ea, ee, es, eto, 2'(mtm), 2'(mcnt)});
        chk("rand_rdat", m_dat, ed);
        if (fwd) chk("rand_adr", s_adr, adr[own*32 +: 32]);
        if (own < 0) begin
            for (int k = 1; k <= 3; k++) begin
                c = (last + k) % 3;
                if (!found && cyc[c]) begin
                    found = 1; own = c; last = c; gshow = c; quiet = 0; ph = 0;
                end
            end
        end else if (ph == 0) begin
            if (!cyc[own]) own = -1;
            else if (s_ack || f_err) quiet = 0;
            else if (quiet == T - 1) ph = 1;
            else quiet++;
        end else if (ph == 1) begin
            ph = 2; mtm = own; mcnt = (mcnt < 3) ? mcnt + 1 : 3;
        end else if (!cyc[own]) begin
            own = -1;
        end
    endtask

    typedef struct {
        logic [2:0] cyc;
        logic       ack;
        logic       gv;
        logic [1:0] g;
        logic       wcyc;
        logic       mack;
    } vec_t;

    initial begin
        vec_t tv[6];
        int rem[3];
        bit drop[3];
        int ng, gs, ec, pulses, hold_bad, rg, dropi, bad, acks;
        logic pgv, seen;
        logic [1:0] rgnt;

        tv[0] = '{3'b010, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
        tv[1] = '{3'b010, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0};
        tv[2] = '{3'b010, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0};
        tv[3] = '{3'b010, 1'b1, 1'b1, 2'd1, 1'b1, 1'b1};
        tv[4] = '{3'b000, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0};
        tv[5] = '{3'b000, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0};

        do_reset();
        we  = 3'b111;
        adr = {32'h2222_0008, 32'h1111_0004, 32'h0000_0000};
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            cyc = tv[k].cyc; stb = tv[k].cyc; f_ack = tv[k].ack;
            @(negedge clk);
            chk("t1_gv", gv, tv[k].gv);
            chk("t1_grant", grant, tv[k].g);
            chk("t1_wbs_cyc", s_cyc, tv[k].wcyc);
            chk("t1_ack", m_ack, {1'b0, tv[k].mack, 1'b0});
            if (tv[k].wcyc) chk("t1_adr", s_adr, 32'h1111_0004);
        end
        f_ack = 1'b0;

        // Three masters, four single transfers each, slave acks immediately.
        do_reset();
        auto_ack = 1'b1;
        rem = '{4, 4, 4}; drop = '{0, 0, 0}; ng = 0; pgv = 0;
        for (int i = 0; i < 200 && ng < 12; i++) begin
            @(posedge clk); #1;
            for (int m = 0; m < 3; m++) begin
                cyc[m] = rem[m] > 0 && !drop[m];
                drop[m] = 0;
            end
            stb = cyc;
            @(negedge clk);
            if (gv && !pgv) begin chk("t2_order", grant, ng % 3); ng++; end
            pgv = gv;
            for (int m = 0; m < 3; m++) if (m_ack[m]) begin rem[m]--; drop[m] = 1; end
        end
        chk("t2_count", ng, 12);
        auto_ack = 1'b0;

        // Master 2 read to a silent slave; master 0 queues behind it.
        do_reset();
        we = '0; gs = -1; ec = -1; pulses = 0; hold_bad = 0; rg = -1; dropi = -1; rgnt = 2'd3;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            cyc[2] = (ec < 0) || (i <= ec + 5);
            cyc[0] = gs >= 0;
            cyc[1] = 1'b0;
            stb = cyc;
            if (dropi < 0 && !cyc[2]) dropi = i;
            @(negedge clk);
            if (gv && gs < 0) gs = i;
            if (m_err[2] && ec < 0) ec = i;
            pulses += int'(to);
            if (ec >= 0 && i > ec && i <= ec + 5 && gv) hold_bad++;
            if (dropi >= 0 && gv && rg < 0) begin rg = i; rgnt = grant; end
        end
        chk("t3_err_latency", ec - gs, T);
        chk("t3_pulses", pulses, 1);
        chk("t3_tmo_master", tmst, 2'd2);
        chk("t3_tmo_count", tcnt, 2'd1);
        chk("t3_hold_no_grant", hold_bad, 0);
        chk("t3_regrant_delay", rg - dropi, 2);
        chk("t3_regrant_idx", rgnt, 2'd0);

        // Ack exactly when the timer reaches its last value, then every 10 cycles.
        do_reset();
        gs = -1; bad = 0; acks = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            cyc = 3'b001; stb = 3'b001;
            f_ack = gs >= 0 && (i - gs) >= 15 && ((i - gs - 15) % 10) == 0;
            @(negedge clk);
            if (gv && gs < 0) gs = i;
            if (m_err != 0 || to) bad++;
            if (m_ack[0]) acks++;
        end
        f_ack = 1'b0;
        chk("t4_no_abort", bad, 0);
        chk("t4_acks", acks, 5);
        chk("t4_tmo_count", tcnt, 2'd0);

        // Saturating timeout counter.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            seen = 0;
            for (int i = 0; i < 40 && !seen; i++) begin
                @(posedge clk); #1;
                cyc = 3'b010; stb = 3'b010;
                @(negedge clk);
                if (to) seen = 1;
            end
            chk("t5_seen", seen, 1'b1);
            @(posedge clk); #1;
            @(negedge clk);
            chk("t5_count", tcnt, (k + 1 > 3) ? 3 : k + 1);
            @(posedge clk); #1;
            cyc = '0; stb = '0;
            @(negedge clk);
        end

        // Asynchronous reset while master 0 owns the bus with stb high.
        seen = 0;
        for (int i = 0; i < 6 && !seen; i++) begin
            @(posedge clk); #1;
            cyc = 3'b001; stb = 3'b001;
            @(negedge clk);
            seen = gv && grant == 2'd0;
        end
        chk("t6_granted", seen, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("t6_wbs_cyc", s_cyc, 1'b0);
        chk("t6_gv", gv, 1'b0);
        chk("t6_count", tcnt, 2'd0);
        chk("t6_tmo_master", tmst, 2'd0);
        @(posedge clk); #1;
        rst = 1'b0; cyc = 3'b011; stb = 3'b011;
        @(negedge clk);
        chk("t6_idle", gv, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t6_first_grant", {gv, grant}, {1'b1, 2'd0});

        // Randomized traffic with alternating responsive and silent slave phases.
        do_reset();
        model_reset();
        for (int i = 0; i < 800; i++) begin
            logic silent;
            silent = ((i / 100) % 2) == 1;
            @(posedge clk); #1;
            for (int m = 0; m < 3; m++) begin
                if ($urandom_range(silent ? 31 : 15) == 0) cyc[m] = ~cyc[m];
                stb[m] = cyc[m] & 1'($urandom_range(1));
                we[m]  = 1'($urandom_range(1));
            end
            adr     = {$urandom, $urandom, $urandom};
            wdat    = {$urandom, $urandom, $urandom};
            sel     = 12'($urandom);
            f_ack   = !silent && $urandom_range(5) == 0;
            f_err   = !silent && $urandom_range(39) == 0;
            s_stall = 1'($urandom_range(1));
            s_rdat  = $urandom;
            @(negedge clk);
            model_check();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
